// File: rtl/mem_arbiter_if.sv
// Cache-pair / RAM port bundle for mem_arbiter.
// master: arbiter side; slave: requesters plus RAM.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ireq;
    logic [ADDR_W-1:0] iaddr;
    logic              dren;
    logic              dwen;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              ihit;
    logic [DATA_W-1:0] iload;
    logic              dhit;
    logic [DATA_W-1:0] dload;
    logic              ram_ren;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_store;
    logic [DATA_W-1:0] ram_load;
    logic              ram_ready;
    logic              arb_err;

    modport master (
        input  ireq, iaddr, dren, dwen, daddr, dstore, ram_load, ram_ready,
        output ihit, iload, dhit, dload, ram_ren, ram_wen, ram_addr, ram_store, arb_err
    );

    modport slave (
        output ireq, iaddr, dren, dwen, daddr, dstore, ram_load, ram_ready,
        input  ihit, iload, dhit, dload, ram_ren, ram_wen, ram_addr, ram_store, arb_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between I-fetch and D load/store; D has priority (MEM_ARB_FAIR_EN: alternate).
// Latency: hit 2 cycles after request plus one per RAM wait cycle; timeout aborts without a hit.
// Backpressure: requests are held until their hit; one access in flight, latched values rule.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       own;        // 1: D side owns the current access
    logic       op_wr;
    logic [7:0] tmo_cnt;
    logic       d_req;
    logic       i_req;
    logic       grant;
    logic       grant_d;
    logic       ram_done;
    logic       tmo_hit;

    assign d_req = bus.dren | bus.dwen;
    assign i_req = bus.ireq;

`ifdef MEM_ARB_FAIR_EN
    logic last_own;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            last_own <= 1'b0;
        else if (state == DONE)
            last_own <= own;
    end

    // Under contention the side that did not own the previous access wins.
    assign grant_d = d_req & (~i_req | ~last_own);
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = BUSY;
            BUSY: begin
                if (ram_done)
                    state_nxt = DONE;
                else if (tmo_hit)
                    state_nxt = IDLE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant    = 1'b0;
        ram_done = 1'b0;
        tmo_hit  = 1'b0;
        case (state)
            IDLE: grant = d_req | i_req;
            BUSY: begin
                ram_done = bus.ram_ready;
                tmo_hit  = ~bus.ram_ready && (tmo_cnt == TMO_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            own           <= 1'b0;
            op_wr         <= 1'b0;
            tmo_cnt       <= '0;
            bus.ihit      <= 1'b0;
            bus.dhit      <= 1'b0;
            bus.iload     <= '0;
            bus.dload     <= '0;
            bus.ram_ren   <= 1'b0;
            bus.ram_wen   <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_store <= '0;
            bus.arb_err   <= 1'b0;
        end else begin
            bus.ihit <= 1'b0;
            bus.dhit <= 1'b0;
            if (grant) begin
                // dren&dwen together resolves to a write
                own           <= grant_d;
                op_wr         <= grant_d & bus.dwen;
                bus.ram_addr  <= grant_d ? bus.daddr : bus.iaddr;
                bus.ram_store <= grant_d ? bus.dstore : '0;
                bus.ram_ren   <= ~(grant_d & bus.dwen);
                bus.ram_wen   <= grant_d & bus.dwen;
                tmo_cnt       <= '0;
            end
            if (ram_done) begin
                bus.ram_ren <= 1'b0;
                bus.ram_wen <= 1'b0;
                if (own) begin
                    bus.dhit  <= 1'b1;
                    bus.dload <= op_wr ? '0 : bus.ram_load;
                end else begin
                    bus.ihit  <= 1'b1;
                    bus.iload <= bus.ram_load;
                end
            end else if (tmo_hit) begin
                bus.ram_ren <= 1'b0;
                bus.ram_wen <= 1'b0;
                bus.arb_err <= 1'b1;
            end else if (state == BUSY) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

    a_no_rw_both: assert property (@(posedge CLK) disable iff (RST) !(bus.dren && bus.dwen));
    a_strobe_excl: assert property (@(posedge CLK) disable iff (RST) !(bus.ram_ren && bus.ram_wen));
    a_hit_excl: assert property (@(posedge CLK) disable iff (RST) !(bus.ihit && bus.dhit));
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester drivers, RAM responder, hit monitor.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
    } dtx_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(255)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] ram_mem[logic [31:0]];
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] iexp[$];
    logic [31:0] dexp[$];
    logic [31:0] iq[$];
    dtx_t        dq[$];
    logic [31:0] grant_log[$];
    bit          wr_log[$];
    int ram_delay = -1;
    int last_cnt  = 0;
    int ihit_cnt  = 0;
    int dhit_cnt  = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction

    // RAM responder: ready arrives in strobe cycle number ram_delay (random 0..3 when negative)
    initial begin
        bit          serving;
        bit          cur_wr;
        bit          addr_ok;
        int          k;
        int          dly;
        logic [31:0] cur_addr;
        logic [31:0] cur_dat;
        serving = 0; cur_wr = 0; addr_ok = 1; k = 0; dly = 0; cur_addr = 0; cur_dat = 0;
        bus.ram_ready = 1'b0;
        bus.ram_load  = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                serving = 0;
                bus.ram_ready = 1'b0;
            end else if (bus.ram_ren || bus.ram_wen) begin
                if (!serving) begin
                    serving  = 1;
                    k        = 0;
                    addr_ok  = 1;
                    cur_addr = bus.ram_addr;
                    cur_wr   = bus.ram_wen;
                    cur_dat  = bus.ram_store;
                    dly      = (ram_delay < 0) ? int'($urandom_range(0, 3)) : ram_delay;
                    grant_log.push_back(cur_addr);
                    wr_log.push_back(cur_wr);
                end else if (bus.ram_addr !== cur_addr || bus.ram_wen !== cur_wr) begin
                    addr_ok = 0;
                end
                k++;
                if (k == dly + 1) begin
                    bus.ram_ready = 1'b1;
                    if (cur_wr) begin
                        ram_mem[cur_addr] = cur_dat;
                        bus.ram_load = $urandom;
                    end else begin
                        bus.ram_load = ram_mem.exists(cur_addr) ? ram_mem[cur_addr] : init_val(cur_addr);
                    end
                    @(posedge CLK);
                    #1 bus.ram_ready = 1'b0;
                end
            end else if (serving) begin
                serving  = 0;
                last_cnt = k;
                check_eq("ram_req_stable", {31'b0, addr_ok}, 32'd1);
            end
        end
    end

    // Hit monitor / scoreboard
    always @(negedge CLK) begin
        logic [31:0] e;
        if (!RST) begin
            if (bus.ihit || bus.dhit)
                check_eq("hit_exclusive", {31'b0, bus.ihit & bus.dhit}, 32'd0);
            if (bus.ram_ren || bus.ram_wen)
                check_eq("strobe_exclusive", {31'b0, bus.ram_ren & bus.ram_wen}, 32'd0);
            if (bus.ihit) begin
                ihit_cnt++;
                if (iexp.size() == 0) begin
                    check_eq("ihit_unexpected", 32'd1, 32'd0);
                end else begin
                    e = iexp.pop_front();
                    check_eq("iload", bus.iload, e);
                end
            end
            if (bus.dhit) begin
                dhit_cnt++;
                if (dexp.size() == 0) begin
                    check_eq("dhit_unexpected", 32'd1, 32'd0);
                end else begin
                    e = dexp.pop_front();
                    check_eq("dload", bus.dload, e);
                end
            end
        end
    end

    task automatic wait_hit(input bit side_d, output bit ok);
        ok = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            if (side_d ? bus.dhit : bus.ihit) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic run_i(input int max_gap);
        logic [31:0] a;
        logic [31:0] junk;
        bit ok;
        while (iq.size() > 0) begin
            a = iq.pop_front();
            @(posedge CLK); #1;
            bus.ireq  = 1'b1;
            bus.iaddr = a;
            iexp.push_back(model_rd(a));
            wait_hit(1'b0, ok);
            if (!ok) begin
                check_eq("ihit_timeout", 32'd0, 32'd1);
                junk = iexp.pop_back();
            end
            if (max_gap > 0) begin
                @(posedge CLK); #1;
                bus.ireq = 1'b0;
                repeat ($urandom_range(0, max_gap)) @(posedge CLK);
            end
        end
        @(posedge CLK); #1;
        bus.ireq = 1'b0;
    endtask

    task automatic run_d(input int max_gap);
        dtx_t t;
        logic [31:0] junk;
        bit ok;
        while (dq.size() > 0) begin
            t = dq.pop_front();
            @(posedge CLK); #1;
            bus.dren   = ~t.wr;
            bus.dwen   = t.wr;
            bus.daddr  = t.a;
            bus.dstore = t.d;
            if (t.wr) begin
                model_mem[t.a] = t.d;
                dexp.push_back(32'd0);
            end else begin
                dexp.push_back(model_rd(t.a));
            end
            wait_hit(1'b1, ok);
            if (!ok) begin
                check_eq("dhit_timeout", 32'd0, 32'd1);
                junk = dexp.pop_back();
            end
            if (max_gap > 0) begin
                @(posedge CLK); #1;
                bus.dren = 1'b0;
                bus.dwen = 1'b0;
                repeat ($urandom_range(0, max_gap)) @(posedge CLK);
            end
        end
        @(posedge CLK); #1;
        bus.dren = 1'b0;
        bus.dwen = 1'b0;
    endtask

    task automatic check_log(input string name, input logic [31:0] exp_q[$]);
        check_eq({name, "_len"}, grant_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++)
            check_eq(name, grant_log[i], exp_q[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_q[$];
        dtx_t t;
        int   d0;
        int   dl;
        int   il;
        int   dn;
        bit   pick_d;
        bit   last_d;
        bit   seen;

        RST = 1'b1;
        bus.ireq = 1'b0; bus.iaddr = '0; bus.dren = 1'b0; bus.dwen = 1'b0;
        bus.daddr = '0; bus.dstore = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_ihit", bus.ihit, 0);
        check_eq("rst_dhit", bus.dhit, 0);
        check_eq("rst_iload", bus.iload, 0);
        check_eq("rst_dload", bus.dload, 0);
        check_eq("rst_ram_ren", bus.ram_ren, 0);
        check_eq("rst_ram_wen", bus.ram_wen, 0);
        check_eq("rst_ram_addr", bus.ram_addr, 0);
        check_eq("rst_ram_store", bus.ram_store, 0);
        check_eq("rst_arb_err", bus.arb_err, 0);
        @(negedge CLK);
        RST = 1'b0;

        // Lone fetch, ready in the second strobe cycle
        ram_mem[32'h100]   = 32'hDEADBEEF;
        model_mem[32'h100] = 32'hDEADBEEF;
        ram_delay = 1;
        d0 = dhit_cnt;
        grant_log.delete(); wr_log.delete();
        iq.push_back(32'h100);
        run_i(0);
        check_eq("t1_ren_cycles", last_cnt, 2);
        check_eq("t1_no_dhit", dhit_cnt, d0);
        check_eq("t1_was_read", {31'b0, wr_log.size() == 1 && wr_log[0] == 1'b0}, 1);

        // Simultaneous fetch and store: store first
        ram_delay = 0;
        grant_log.delete(); wr_log.delete();
        iq.push_back(32'h200);
        t = '{wr: 1'b1, a: 32'h400, d: 32'h12345678};
        dq.push_back(t);
        fork
            run_i(0);
            run_d(0);
        join
        exp_q = '{32'h400, 32'h200};
        check_log("t2_order", exp_q);
        check_eq("t2_first_is_write", {31'b0, wr_log.size() > 0 && wr_log[0] == 1'b1}, 1);
        check_eq("t2_ram_written", ram_mem.exists(32'h400) ? ram_mem[32'h400] : 32'h0, 32'h12345678);

        // Back-to-back D reads with a held fetch (previous owner was I)
        ram_delay = -1;
        grant_log.delete(); wr_log.delete();
        for (int i = 0; i < 6; i++) begin
            t = '{wr: 1'b0, a: 32'h2000 + 32'(4 * i), d: 32'h0};
            dq.push_back(t);
        end
        iq.push_back(32'h1000);
        exp_q.delete();
        dl = 6; il = 1; dn = 0; last_d = 1'b0;
        while (dl > 0 || il > 0) begin
`ifdef MEM_ARB_FAIR_EN
            pick_d = (dl > 0) && (il == 0 || !last_d);
`else
            pick_d = (dl > 0);
`endif
            if (pick_d) begin
                exp_q.push_back(32'h2000 + 32'(4 * dn));
                dn++;
                dl--;
            end else begin
                exp_q.push_back(32'h1000);
                il--;
            end
            last_d = pick_d;
        end
        fork
            run_i(0);
            run_d(0);
        join
        check_log("t3_order", exp_q);

        // Request address changes mid-access
        ram_delay = 4;
        t = '{wr: 1'b0, a: 32'h40, d: 32'h0};
        dq.push_back(t);
        fork
            run_d(0);
            begin
                repeat (3) @(posedge CLK);
                #2 bus.daddr = 32'h999;
                @(negedge CLK);
                check_eq("t6_addr_latched", bus.ram_addr, 32'h40);
            end
        join

        // Timeout abort
        ram_delay = 100000;
        d0 = dhit_cnt;
        @(posedge CLK); #1;
        bus.dren  = 1'b1;
        bus.daddr = 32'h40;
        seen = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            if (bus.ram_ren) seen = 1;
            else if (seen) break;
        end
        bus.dren = 1'b0;
        @(posedge CLK); #1;
        check_eq("t4_strobe_cycles", last_cnt, 255);
        check_eq("t4_arb_err", bus.arb_err, 1);
        repeat (5) @(posedge CLK);
        #1;
        check_eq("t4_no_dhit", dhit_cnt, d0);
        check_eq("t4_no_regrant", bus.ram_ren | bus.ram_wen, 0);
        ram_delay = -1;
        iq.push_back(32'h1004);
        run_i(0);
        check_eq("t4_err_sticky", bus.arb_err, 1);

        // Reset mid-access
        ram_delay = 100000;
        @(posedge CLK); #1;
        bus.ireq  = 1'b1;
        bus.iaddr = 32'h1100;
        repeat (3) @(negedge CLK);
        check_eq("t5_busy_ren", bus.ram_ren, 1);
        #2 RST = 1'b1;
        #1;
        check_eq("t5_ram_ren", bus.ram_ren, 0);
        check_eq("t5_ram_wen", bus.ram_wen, 0);
        check_eq("t5_ihit", bus.ihit, 0);
        check_eq("t5_dhit", bus.dhit, 0);
        check_eq("t5_arb_err", bus.arb_err, 0);
        bus.ireq = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        ram_delay = -1;
        iq.push_back(32'h1108);
        run_i(0);

        // Randomized contention
        for (int i = 0; i < 20; i++) begin
            iq.push_back(32'h1000 + 32'(4 * $urandom_range(0, 63)));
            t.wr = 1'($urandom_range(0, 1));
            t.a  = 32'h2000 + 32'(4 * $urandom_range(0, 63));
            t.d  = $urandom;
            dq.push_back(t);
        end
        fork
            run_i(3);
            run_d(3);
        join

        repeat (5) @(posedge CLK);
        check_eq("iexp_drained", iexp.size(), 0);
        check_eq("dexp_drained", dexp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
